// File: rtl/collapse_key_assembler_if.sv
// Bundle between the key assembler, the collapse-register bank and the key consumer.
// master: the assembler itself; slave: the bank/consumer side.
interface collapse_key_assembler_if #(
    parameter int unsigned NUM_FRAGS = 16,
    parameter int unsigned IDX_W     = $clog2(NUM_FRAGS)
);
    logic                   start;
    logic                   abort;
    logic [IDX_W-1:0]       frag_sel;
    logic                   frag_read;
    logic [7:0]             frag_data;
    logic                   frag_oe;
    logic [8*NUM_FRAGS-1:0] key_out;
    logic                   key_valid;
    logic                   key_ready;
    logic                   busy;
    logic                   error;
    logic [IDX_W-1:0]       err_idx;

    modport master (
        input  start, abort, frag_data, frag_oe, key_ready,
        output frag_sel, frag_read, key_out, key_valid, busy, error, err_idx
    );

    modport slave (
        output start, abort, frag_data, frag_oe, key_ready,
        input  frag_sel, frag_read, key_out, key_valid, busy, error, err_idx
    );
endinterface

// File: rtl/collapse_key_assembler.sv
// Reads a bank of read-once collapse registers in index order, one strobe every other
// cycle, and releases the assembled key over valid/ready before zeroizing it.
module collapse_key_assembler #(
    parameter int unsigned NUM_FRAGS = 16,
    parameter int unsigned IDX_W     = $clog2(NUM_FRAGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    collapse_key_assembler_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_GAP,
        S_DONE,
        S_FAIL
    } state_e;

    localparam int unsigned KEY_W = 8 * NUM_FRAGS;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [KEY_W-1:0]   key_q,   key_d;
    logic               error_q, error_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;

    logic               last_frag;

    assign last_frag = (idx_q == IDX_W'(NUM_FRAGS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            key_q     <= '0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            key_q     <= key_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        key_d     = key_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d   = S_READ;
                    idx_d     = '0;
                    key_d     = '0;
                    error_d   = 1'b0;
                    err_idx_d = '0;
                end
            end
            S_READ: begin
                if (bus.frag_oe) begin
                    for (int unsigned i = 0; i < NUM_FRAGS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            key_d[8*i +: 8] = bus.frag_data;
                        end
                    end
                    if (last_frag) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GAP;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d   = S_FAIL;
                    error_d   = 1'b1;
                    err_idx_d = idx_q;
                    key_d     = '0;
                end
            end
            S_GAP: begin
                state_d = S_READ;
            end
            S_DONE: begin
                if (bus.key_ready) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    key_d   = '0;
                end
            end
            S_FAIL: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                key_d   = '0;
            end
        endcase

        // Abort overrides whatever the state decided this cycle, including a failure flag.
        if (bus.abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            idx_d     = '0;
            key_d     = '0;
            error_d   = error_q;
            err_idx_d = err_idx_q;
        end
    end

    assign bus.frag_sel  = idx_q;
    assign bus.frag_read = (state_q == S_READ) && !bus.abort;
    assign bus.key_valid = (state_q == S_DONE);
    assign bus.key_out   = (state_q == S_DONE) ? key_q : '0;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.error     = error_q;
    assign bus.err_idx   = err_idx_q;

    // A collapse register must never see two strobes in a row.
    property p_no_back_to_back;
        @(posedge clk) disable iff (reset) bus.frag_read |=> !bus.frag_read;
    endproperty
    a_no_back_to_back: assert property (p_no_back_to_back);

endmodule

// File: tb/tb_collapse_key_assembler.sv
// Directed bench for collapse_key_assembler: behavioural cycle model plus hand-computed checks.
module tb_collapse_key_assembler;
    localparam int unsigned N     = 16;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned KW    = 8 * N;

    logic clk;
    logic reset;

    collapse_key_assembler_if #(.NUM_FRAGS(N), .IDX_W(IDX_W)) bus ();

    collapse_key_assembler #(.NUM_FRAGS(N), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] frag_mem [N];
    logic       oe_mem   [N];

    assign bus.frag_data = frag_mem[bus.frag_sel];
    assign bus.frag_oe   = oe_mem[bus.frag_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 reading (k = cycle number since start), 2 failed, 3 key held.
    int               m_phase = 0;
    int               m_k     = 0;
    logic [KW-1:0]    m_key   = '0;
    logic             m_err   = 1'b0;
    int               m_err_idx = 0;
    bit               model_ok = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_phase = 0; m_k = 0; m_key = '0; m_err = 1'b0; m_err_idx = 0;
                model_ok = 1'b1;
            end else begin
                case (m_phase)
                    0: if (bus.start && !bus.abort) begin
                        m_phase = 1; m_k = 1; m_key = '0; m_err = 1'b0; m_err_idx = 0;
                    end
                    1: begin
                        if (bus.abort) begin
                            m_phase = 0; m_key = '0;
                        end else if (m_k % 2 == 1) begin
                            if (oe_mem[m_k / 2]) begin
                                m_key[8*(m_k/2) +: 8] = frag_mem[m_k / 2];
                                if (m_k / 2 == N - 1) m_phase = 3;
                                else m_k++;
                            end else begin
                                m_phase = 2; m_err = 1'b1; m_err_idx = m_k / 2; m_key = '0;
                            end
                        end else begin
                            m_k++;
                        end
                    end
                    2: m_phase = 0;
                    3: if (bus.abort || bus.key_ready) begin
                        m_phase = 0; m_key = '0;
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    int  strobe_cnt [N];
    bit  prev_read  = 1'b0;
    bit  valid_seen = 1'b0;

    // Compare process: every negedge once the model has seen a reset edge.
    initial begin
        int exp_sel;
        forever begin
            @(negedge clk);
            if (model_ok) begin
                exp_sel = (m_phase == 0) ? 0 : (m_phase == 1) ? m_k / 2 :
                          (m_phase == 3) ? N - 1 : m_err_idx;
                chk("busy",      KW'(bus.busy),      KW'(m_phase != 0));
                chk("key_valid", KW'(bus.key_valid), KW'(m_phase == 3));
                chk("key_out",   bus.key_out,        (m_phase == 3) ? m_key : '0);
                chk("frag_read", KW'(bus.frag_read),
                    KW'(m_phase == 1 && (m_k % 2 == 1) && !bus.abort));
                chk("frag_sel",  KW'(bus.frag_sel),  KW'(exp_sel));
                chk("error",     KW'(bus.error),     KW'(m_err));
                chk("err_idx",   KW'(bus.err_idx),   KW'(m_err_idx));
                if (bus.frag_read === 1'b1) begin
                    chk("single_strobe", KW'(strobe_cnt[bus.frag_sel]), '0);
                    chk("no_b2b_strobe", KW'(prev_read), '0);
                    strobe_cnt[bus.frag_sel]++;
                end
                prev_read = (bus.frag_read === 1'b1);
                if (bus.key_valid === 1'b1) valid_seen = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bank(input int fail_idx);
        for (int i = 0; i < N; i++) begin
            frag_mem[i] = 8'(8'h10 + i);
            oe_mem[i]   = (i != fail_idx);
        end
    endtask

    task automatic clear_strobes();
        for (int i = 0; i < N; i++) strobe_cnt[i] = 0;
        valid_seen = 1'b0;
    endtask

    function automatic int total_strobes();
        int s = 0;
        for (int i = 0; i < N; i++) s += strobe_cnt[i];
        return s;
    endfunction

    // Pulse start for one edge; afterwards the bench sits in cycle 1 (first READ).
    task automatic kick();
        clear_strobes();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Returns the cycle number (cycle 1 = first READ) at which key_valid is first seen.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (bus.key_valid !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        int            cyc;
        logic [KW-1:0] kv;

        bus.start = 1'b0; bus.abort = 1'b0; bus.key_ready = 1'b0;
        set_bank(-1);
        clear_strobes();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        chk("rst_key_out", bus.key_out, '0);
        chk("rst_busy", KW'(bus.busy), '0);
        chk("rst_sel", KW'(bus.frag_sel), '0);

        // abort beats start in IDLE
        bus.start = 1'b1; bus.abort = 1'b1;
        step();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("abort_over_start", KW'(bus.busy), '0);

        // happy path + backpressure
        kick();
        wait_valid(cyc);
        chk("valid_cycle", KW'(cyc), KW'(2 * N));
        chk("happy_strobes", KW'(total_strobes()), KW'(N));
        kv = bus.key_out;
        chk("key_byte0", KW'(kv[7:0]), KW'(8'h10));
        chk("key_byte15", KW'(kv[127:120]), KW'(8'h1F));
        for (int i = 0; i < 10; i++) begin
            bus.start = (i % 3 == 0);
            step();
            chk("bp_valid", KW'(bus.key_valid), KW'(1'b1));
            chk("bp_key", bus.key_out, kv);
        end
        bus.start = 1'b0;
        chk("bp_no_restrobe", KW'(total_strobes()), KW'(N));
        bus.key_ready = 1'b1;
        step();
        bus.key_ready = 1'b0;
        chk("post_ready_key", bus.key_out, '0);
        chk("post_ready_busy", KW'(bus.busy), '0);

        // dead fragment at index 5
        set_bank(5);
        kick();
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("dead_idle", KW'(bus.busy), '0);
        chk("dead_error", KW'(bus.error), KW'(1'b1));
        chk("dead_err_idx", KW'(bus.err_idx), KW'(5));
        chk("dead_strobes", KW'(total_strobes()), KW'(6));
        chk("dead_no_valid", KW'(valid_seen), '0);

        // retry after the failure
        set_bank(-1);
        kick();
        chk("retry_err_clear", KW'(bus.error), '0);
        wait_valid(cyc);
        chk("retry_cycle", KW'(cyc), KW'(2 * N));
        kv = bus.key_out;
        chk("retry_byte5", KW'(kv[47:40]), KW'(8'h15));
        bus.key_ready = 1'b1;
        step();
        bus.key_ready = 1'b0;

        // abort while strobing index 7
        kick();
        for (int i = 0; i < 14; i++) step();
        chk("pre_abort_sel", KW'(bus.frag_sel), KW'(7));
        bus.abort = 1'b1;
        #1;
        chk("abort_gates_read", KW'(bus.frag_read), '0);
        step();
        bus.abort = 1'b0;
        chk("abort_idle", KW'(bus.busy), '0);
        chk("abort_no_error", KW'(bus.error), '0);
        chk("abort_strobes", KW'(total_strobes()), KW'(7));
        chk("abort_idx7_untouched", KW'(strobe_cnt[7]), '0);
        kick();
        chk("restart_sel", KW'(bus.frag_sel), '0);
        chk("restart_read", KW'(bus.frag_read), KW'(1'b1));

        // sub-cycle reset glitch mid-run is ignored
        for (int i = 0; i < 4; i++) step();
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        wait_valid(cyc);
        chk("glitch_cycle", KW'(cyc + 4), KW'(2 * N));
        bus.key_ready = 1'b1;
        step();
        bus.key_ready = 1'b0;

        // synchronous reset while strobing index 9
        kick();
        for (int i = 0; i < 18; i++) step();
        chk("pre_reset_sel", KW'(bus.frag_sel), KW'(9));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_busy", KW'(bus.busy), '0);
        chk("rst_mid_sel", KW'(bus.frag_sel), '0);
        chk("rst_mid_read", KW'(bus.frag_read), '0);
        chk("rst_mid_key", bus.key_out, '0);
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule
